tx_bit_shifter: RTL and testbench

//  Output stage of the UART TX core, downstream of the TX state machine.
//  - Consumes state, bit index and parity trigger from the state machine.
//  - Pops one byte from the TX FIFO per frame and computes its parity.
//  - Drives the serial tx line, registered, for start, data, parity and stop bits.
//  - Data, parity and tx registers each have three copies, majority-voted.

---
 rtl/tx_bit_shifter.sv | 128 ++++++++++++
 tb/tb_tx_bit_shifter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_bit_shifter.sv
// UART TX output stage: pops one FIFO byte per frame, computes parity and
// drives the registered serial line. Data, parity and tx are triplicated and voted.

module tx_bit_shifter_tmr #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [2:0][W-1:0] copy_q;

   // All copies are loaded together; a single upset is outvoted by the other two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < 3; c++) copy_q[c] <= RST_VAL;
      end else if (en_i) begin
         for (int c = 0; c < 3; c++) copy_q[c] <= d_i;
      end
   end

   assign q_o = (copy_q[0] & copy_q[1]) | (copy_q[0] & copy_q[2]) | (copy_q[1] & copy_q[2]);
endmodule

module tx_bit_shifter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            State_i,
   input  logic [3:0]            BitCounter_i,
   input  logic                  p_ParityCalTrigger_i,
   input  logic                  ParityOdd_i,
   input  logic                  MsbFirst_i,
   input  logic [DATA_WIDTH-1:0] FifoData_i,
   output logic                  p_FifoRead_o,
   output logic                  Tx_o,
   output logic                  p_ByteDone_o
);
   localparam logic [4:0] ST_INTERVAL = 5'b00001;
   localparam logic [4:0] ST_START    = 5'b00010;
   localparam logic [4:0] ST_DATA     = 5'b00100;
   localparam logic [4:0] ST_PARITY   = 5'b01000;
   localparam logic [4:0] ST_STOP     = 5'b10000;
   localparam logic [3:0] LAST_IDX    = 4'(DATA_WIDTH - 1);
   localparam logic [4:0] WIDTH_5     = 5'(DATA_WIDTH);

   logic [4:0]            prev_state_q;
   logic                  cfg_odd_q, cfg_msb_q;
   logic                  rd_q, rd_dly_q, done_q;
   logic                  start_edge, frame_end;
   logic [DATA_WIDTH-1:0] data_v, data_shift;
   logic                  parity_v, parity_d;
   logic                  tx_d;
   logic [3:0]            bit_idx;

   assign start_edge = (State_i == ST_START) && (prev_state_q != ST_START);
   assign frame_end  = (prev_state_q == ST_STOP) && (State_i == ST_INTERVAL);

   // Strobes are registered so nothing reaches the FIFO while rst is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_state_q <= ST_INTERVAL;
         cfg_odd_q    <= 1'b0;
         cfg_msb_q    <= 1'b0;
         rd_q         <= 1'b0;
         rd_dly_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         prev_state_q <= State_i;
         rd_q         <= start_edge;
         rd_dly_q     <= rd_q;
         done_q       <= frame_end;
         if (start_edge) begin
            cfg_odd_q <= ParityOdd_i;
            cfg_msb_q <= MsbFirst_i;
         end
      end
   end

   // FIFO read data is valid the cycle after the pop strobe.
   tx_bit_shifter_tmr #(.W(DATA_WIDTH), .RST_VAL('0)) u_data (
      .clk  (clk),
      .rst  (rst),
      .en_i (rd_dly_q),
      .d_i  (FifoData_i),
      .q_o  (data_v)
   );

   assign parity_d = (^data_v) ^ cfg_odd_q;

   tx_bit_shifter_tmr #(.W(1), .RST_VAL(1'b0)) u_parity (
      .clk  (clk),
      .rst  (rst),
      .en_i (p_ParityCalTrigger_i),
      .d_i  (parity_d),
      .q_o  (parity_v)
   );

   assign bit_idx    = cfg_msb_q ? (LAST_IDX - BitCounter_i) : BitCounter_i;
   assign data_shift = data_v >> bit_idx;

   always_comb begin
      tx_d = 1'b1;
      case (State_i)
         ST_INTERVAL: tx_d = 1'b1;
         ST_START:    tx_d = 1'b0;
         ST_DATA:     tx_d = ({1'b0, BitCounter_i} >= WIDTH_5) ? 1'b1 : data_shift[0];
         ST_PARITY:   tx_d = parity_v;
         ST_STOP:     tx_d = 1'b1;
         default:     tx_d = 1'b1;
      endcase
   end

   tx_bit_shifter_tmr #(.W(1), .RST_VAL(1'b1)) u_tx (
      .clk  (clk),
      .rst  (rst),
      .en_i (1'b1),
      .d_i  (tx_d),
      .q_o  (Tx_o)
   );

   assign p_FifoRead_o = rd_q;
   assign p_ByteDone_o = done_q;
endmodule

// File: tb/tb_tx_bit_shifter.sv
// Bench for tx_bit_shifter: a behavioural frame model builds the expected
// serial bit list per byte; directed cases plus random frames.

module tb_tx_bit_shifter;
   localparam int BAUD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] State_i;
   logic [3:0] BitCounter_i;
   logic       p_ParityCalTrigger_i;
   logic       ParityOdd_i;
   logic       MsbFirst_i;
   logic [7:0] FifoData_i;
   logic       p_FifoRead_o;
   logic       Tx_o;
   logic       p_ByteDone_o;

   int vectors = 0;
   int miscompares = 0;
   int rd_cnt = 0;
   int done_cnt = 0;
   logic [7:0] fifo_q[$];

   tx_bit_shifter #(.DATA_WIDTH(8)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .State_i              (State_i),
      .BitCounter_i         (BitCounter_i),
      .p_ParityCalTrigger_i (p_ParityCalTrigger_i),
      .ParityOdd_i          (ParityOdd_i),
      .MsbFirst_i           (MsbFirst_i),
      .FifoData_i           (FifoData_i),
      .p_FifoRead_o         (p_FifoRead_o),
      .Tx_o                 (Tx_o),
      .p_ByteDone_o         (p_ByteDone_o)
   );

   always #5 clk = ~clk;

   // Synchronous-read FIFO: data appears the cycle after the pop.
   always @(posedge clk)
      if (p_FifoRead_o === 1'b1 && fifo_q.size() > 0) FifoData_i <= fifo_q.pop_front();

   always @(negedge clk) begin
      if (p_FifoRead_o === 1'b1) rd_cnt++;
      if (p_ByteDone_o === 1'b1) done_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_en, input bit odd,
                             input bit msb, input bit flip);
      bit exp[$];
      int r0, d0, k;
      r0 = rd_cnt;
      d0 = done_cnt;
      fifo_q.push_back(b);
      exp.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp.push_back(msb ? b[7-i] : b[i]);
      if (par_en) exp.push_back(bit'(($countones(b) % 2) != 0) ^ odd);
      exp.push_back(1'b1);

      ParityOdd_i = odd;
      MsbFirst_i  = msb;
      State_i     = 5'b00010;
      tick(BAUD/2);
      chk("start_bit", {31'd0, Tx_o}, {31'd0, exp[0]});
      tick(BAUD/2);
      for (int i = 0; i < 8; i++) begin
         State_i      = 5'b00100;
         BitCounter_i = 4'(i);
         if (i == 7) p_ParityCalTrigger_i = 1'b1;
         tick(1);
         p_ParityCalTrigger_i = 1'b0;
         if (flip && i == 3) begin
            MsbFirst_i  = ~msb;
            ParityOdd_i = ~odd;
         end
         tick(BAUD/2 - 1);
         chk($sformatf("data_bit%0d", i), {31'd0, Tx_o}, {31'd0, exp[i+1]});
         tick(BAUD/2);
      end
      k = 9;
      if (par_en) begin
         State_i = 5'b01000;
         tick(BAUD/2);
         chk("parity_bit", {31'd0, Tx_o}, {31'd0, exp[k]});
         k++;
         tick(BAUD/2);
      end
      State_i = 5'b10000;
      tick(BAUD/2);
      chk("stop_bit", {31'd0, Tx_o}, {31'd0, exp[k]});
      tick(BAUD/2);
      State_i = 5'b00001;
      tick(3);
      chk("idle_after_frame", {31'd0, Tx_o}, 32'd1);
      chk("reads_per_frame", rd_cnt - r0, 32'd1);
      chk("done_per_frame", done_cnt - d0, 32'd1);
   endtask

   initial begin
      int r0, d0;
      rst = 1'b0;
      State_i = 5'b00001;
      BitCounter_i = 4'd0;
      p_ParityCalTrigger_i = 1'b0;
      ParityOdd_i = 1'b0;
      MsbFirst_i = 1'b0;
      FifoData_i = 8'h00;

      // Reset and idle
      tick(3);
      chk("reset_tx", {31'd0, Tx_o}, 32'd1);
      chk("reset_read", {31'd0, p_FifoRead_o}, 32'd0);
      chk("reset_done", {31'd0, p_ByteDone_o}, 32'd0);
      rst = 1'b1;
      tick(5);
      chk("idle_tx", {31'd0, Tx_o}, 32'd1);
      chk("idle_reads", rd_cnt, 32'd0);
      chk("idle_dones", done_cnt, 32'd0);

      // 0xA5 without parity, then even and odd parity
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);

      // MSB first, config flipped mid-frame
      send_frame(8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h80, 1'b1, 1'b0, 1'b1, 1'b1);

      // Reset mid-frame while the line is low
      r0 = rd_cnt;
      d0 = done_cnt;
      fifo_q.push_back(8'h00);
      ParityOdd_i = 1'b0;
      MsbFirst_i  = 1'b0;
      State_i = 5'b00010;
      tick(BAUD);
      State_i = 5'b00100;
      BitCounter_i = 4'd0;
      tick(3);
      chk("pre_reset_tx_low", {31'd0, Tx_o}, 32'd0);
      rst = 1'b0;
      #1;
      chk("async_reset_tx", {31'd0, Tx_o}, 32'd1);
      State_i = 5'b00001;
      tick(4);
      rst = 1'b1;
      tick(4);
      chk("reset_reads", rd_cnt - r0, 32'd1);
      chk("reset_no_done", done_cnt - d0, 32'd0);
      send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

      // Illegal states and out-of-range bit index
      r0 = rd_cnt;
      d0 = done_cnt;
      State_i = 5'b00100;
      BitCounter_i = 4'd0;
      tick(2);
      chk("databit_low", {31'd0, Tx_o}, 32'd0);
      State_i = 5'b00011;
      tick(2);
      chk("state_00011", {31'd0, Tx_o}, 32'd1);
      State_i = 5'b00100;
      tick(2);
      chk("databit_low2", {31'd0, Tx_o}, 32'd0);
      State_i = 5'b00000;
      tick(2);
      chk("state_00000", {31'd0, Tx_o}, 32'd1);
      State_i = 5'b00100;
      BitCounter_i = 4'd9;
      tick(2);
      chk("bitidx_9", {31'd0, Tx_o}, 32'd1);
      BitCounter_i = 4'd15;
      tick(2);
      chk("bitidx_15", {31'd0, Tx_o}, 32'd1);
      State_i = 5'b00001;
      tick(2);
      chk("illegal_no_read", rd_cnt - r0, 32'd0);
      chk("illegal_no_done", done_cnt - d0, 32'd0);

      // Random frames
      for (int n = 0; n < 20; n++) begin
         send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
